// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scan scheduler for a 4-digit multiplexed 7-segment display.
// Rotates the digit slots, blanks the first GUARD_CYC cycles of every slot against
// ghosting, applies PWM brightness and takes new digit values over valid/ready.
// New values are promoted only on the slot 3->0 wrap so a frame never mixes digits.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros on digits 3..1.
module seg_scan_ctrl #(
    parameter int TICK_DIV  = 10000,
    parameter int GUARD_CYC = 16,
    parameter int BRIGHT_W  = 3
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [15:0]         load_data,
    input  logic [3:0]          load_dp,
    input  logic [3:0]          digit_en,
    input  logic [BRIGHT_W-1:0] bright,
    output logic [3:0]          an,
    output logic [7:0]          cat,
    output logic [1:0]          slot_sel,
    output logic                frame_done
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] GUARD_LAST = TICK_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);

    typedef enum logic {S_GUARD, S_ACTIVE} state_t;

    state_t              state;
    logic [TICK_W-1:0]   tick;
    logic [BRIGHT_W-1:0] pwm;
    logic [BRIGHT_W-1:0] bright_s;
    logic [3:0]          en_s;
    logic [15:0]         active_data;
    logic [3:0]          active_dp;
    logic [15:0]         pend_data;
    logic [3:0]          pend_dp;
    logic                pending;
    logic                pending_next;
    logic                tick_wrap;
    logic                frame_wrap;
    logic                accept;
    logic [3:0]          nibble;
    logic                dp_bit;
    logic                lz_blank;
    logic                show;
    logic [3:0]          an_p0;
    logic [7:0]          cat_p0;

    // Hex nibble to active-low segments, bit order g..a
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tick_wrap  = (tick == TICK_LAST);
    assign frame_wrap = tick_wrap && (slot_sel == 2'd3);
    assign accept     = load_valid && load_ready;

    // Slot timing: tick counter, slot rotation, GUARD/ACTIVE phase, PWM phase, per-slot samples
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tick       <= '0;
            slot_sel   <= 2'd0;
            state      <= S_GUARD;
            pwm        <= '0;
            bright_s   <= '0;
            en_s       <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_wrap;
            if (tick == '0) begin
                bright_s <= bright;
                en_s     <= digit_en;
            end
            if (tick_wrap) begin
                tick     <= '0;
                slot_sel <= slot_sel + 2'd1;
                pwm      <= '0;
                state    <= (GUARD_CYC == 0) ? S_ACTIVE : S_GUARD;
            end else begin
                tick <= tick + TICK_W'(1);
                pwm  <= pwm + BRIGHT_W'(1);
                if ((GUARD_CYC > 0) && (tick == GUARD_LAST)) begin
                    state <= S_ACTIVE;
                end
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank digits 3..1 while they and every higher digit are zero and their dp is off
    always_comb begin
        lz_blank = 1'b0;
        case (slot_sel)
            2'd3:    lz_blank = (active_data[15:12] == 4'h0)  && !active_dp[3];
            2'd2:    lz_blank = (active_data[15:8]  == 8'h0)  && !active_dp[2];
            2'd1:    lz_blank = (active_data[15:4]  == 12'h0) && !active_dp[1];
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Pick the current slot's digit and decide whether it is lit this cycle;
    // pwm <= bright_s is the duty test pwm < bright_s+1 without widening
    always_comb begin
        nibble = active_data[4*slot_sel +: 4];
        dp_bit = active_dp[slot_sel];
        show   = (state == S_ACTIVE) && (pwm <= bright_s) && en_s[slot_sel] && !lz_blank;
        an_p0  = 4'hF;
        cat_p0 = 8'hFF;
        if (show) begin
            an_p0  = ~(4'b0001 << slot_sel);
            cat_p0 = {~dp_bit, seg_decode(nibble)};
        end
    end

    // Pending occupancy: cleared when a frame wrap promotes it, set by an accepted load
    always_comb begin
        pending_next = pending;
        if (frame_wrap && pending) pending_next = 1'b0;
        if (accept)                pending_next = 1'b1;
    end

    // Double-buffered digits: loads land in pending, active changes only at the frame wrap
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            active_data <= 16'h0;
            active_dp   <= 4'h0;
            pend_data   <= 16'h0;
            pend_dp     <= 4'h0;
            pending     <= 1'b0;
            load_ready  <= 1'b1;
        end else begin
            if (frame_wrap && pending) begin
                active_data <= pend_data;
                active_dp   <= pend_dp;
            end
            if (accept) begin
                pend_data <= load_data;
                pend_dp   <= load_dp;
            end
            pending    <= pending_next;
            load_ready <= !pending_next;
        end
    end

    // Register the pin drivers so anodes and cathodes switch together, glitch-free
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'hF;
            cat <= 8'hFF;
        end else begin
            an  <= an_p0;
            cat <= cat_p0;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (TICK_DIV=8, GUARD_CYC=2, BRIGHT_W=2).
// Accepted loads are queued; each queued value is popped when its frame is displayed.
module tb_seg_scan_ctrl;

    localparam int TICK_DIV  = 8;
    localparam int GUARD_CYC = 2;
    localparam int BRIGHT_W  = 2;
    // Output at tick 5 reflects tick 4, where pwm is 0, so the digit is lit at any brightness
    localparam int SAMPLE_TICK = 5;

    logic                clk_in = 1'b0;
    logic                rst_n;
    logic                load_valid;
    logic                load_ready;
    logic [15:0]         load_data;
    logic [3:0]          load_dp;
    logic [3:0]          digit_en;
    logic [BRIGHT_W-1:0] bright;
    logic [3:0]          an;
    logic [7:0]          cat;
    logic [1:0]          slot_sel;
    logic                frame_done;

    int checks   = 0;
    int failures = 0;
    logic [19:0] exp_q[$];

    seg_scan_ctrl #(.TICK_DIV(TICK_DIV), .GUARD_CYC(GUARD_CYC), .BRIGHT_W(BRIGHT_W)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_dp(load_dp), .digit_en(digit_en), .bright(bright),
        .an(an), .cat(cat), .slot_sel(slot_sel), .frame_done(frame_done)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;  4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;  4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;  4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;  4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;  4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Expected {an, cat} for a lit sample of slot s
    function automatic logic [11:0] exp_out(input int s, input logic [15:0] d,
                                            input logic [3:0] p, input logic [3:0] en);
        logic [3:0] a;
        logic       blank;
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (s > 0 && (d >> (4 * s)) == 16'h0 && !p[s]) blank = 1'b1;
`endif
        if (!en[s] || blank) return {4'hF, 8'hFF};
        a = 4'b0001 << s;
        a = ~a;
        return {a, ~p[s], ref_seg(d[4*s +: 4])};
    endfunction

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Offer one load, hold it until accepted, queue the expected value
    task automatic send(input logic [15:0] d, input logic [3:0] p, output bit ok);
        load_data  = d;
        load_dp    = p;
        load_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (load_ready) begin
                @(posedge clk_in);
                ok = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        @(negedge clk_in);
        load_valid = 1'b0;
        if (ok) exp_q.push_back({p, d});
    endtask

    // Record one lit sample per slot; idx counts negedges from the frame_done negedge
    task automatic capture_frame(input int start_idx, output logic [15:0] an_all,
                                 output logic [31:0] cat_all, output logic [7:0] sel_all,
                                 output bit ok);
        int idx;
        ok = 1'b1;
        idx = start_idx;
        an_all = '1;
        cat_all = '1;
        sel_all = '0;
        if (idx < 0) begin
            wait_frame(ok);
            idx = 0;
        end
        if (ok) begin
            for (int s = 0; s < 4; s++) begin
                while (idx < TICK_DIV * s + SAMPLE_TICK) begin
                    @(negedge clk_in);
                    idx++;
                end
                an_all[4*s +: 4]  = an;
                cat_all[8*s +: 8] = cat;
                sel_all[2*s +: 2] = slot_sel;
            end
        end
    endtask

    task automatic test_reset;
        logic [15:0] a; logic [31:0] c; logic [7:0] sl; logic [11:0] e; bit ok;
        rst_n = 1'b1; load_valid = 1'b0; load_data = 16'h0; load_dp = 4'h0;
        digit_en = 4'hF; bright = 2'd3;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL reset_an: got %h want F", an); end
        checks++; if (cat !== 8'hFF) begin failures++; $display("FAIL reset_cat: got %h want FF", cat); end
        checks++; if (slot_sel !== 2'd0) begin failures++; $display("FAIL reset_slot: got %0d want 0", slot_sel); end
        checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", load_ready); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        @(negedge clk_in);
        rst_n = 1'b1;
        capture_frame(-1, a, c, sl, ok);
        checks++; if (!ok) begin failures++; $display("FAIL reset_frame: frame_done timeout"); end
        for (int s = 0; s < 4; s++) begin
            e = exp_out(s, 16'h0, 4'h0, 4'hF);
            checks++;
            if ({a[4*s +: 4], c[8*s +: 8]} !== e) begin
                failures++;
                $display("FAIL reset_display slot%0d: got an=%b cat=%b want an=%b cat=%b",
                         s, a[4*s +: 4], c[8*s +: 8], e[11:8], e[7:0]);
            end
        end
    endtask

    task automatic test_load_display;
        logic [15:0] a; logic [31:0] c; logic [7:0] sl; logic [11:0] e; logic [19:0] q; bit ok;
        digit_en = 4'hF; bright = 2'd3;
        wait_frame(ok);
        send(16'h1234, 4'b0001, ok);
        checks++; if (!ok) begin failures++; $display("FAIL load_accept: not accepted"); end
        capture_frame(-1, a, c, sl, ok);
        checks++; if (!ok) begin failures++; $display("FAIL load_frame: frame_done timeout"); end
        q = (exp_q.size() > 0) ? exp_q.pop_front() : 20'h0;
        checks++; if (a[3:0] !== 4'b1110) begin failures++; $display("FAIL load_an0: got %b want 1110", a[3:0]); end
        checks++; if (c[7:0] !== 8'b00011001) begin failures++; $display("FAIL load_cat0: got %b want 00011001", c[7:0]); end
        checks++; if (a[7:4] !== 4'b1101) begin failures++; $display("FAIL load_an1: got %b want 1101", a[7:4]); end
        checks++; if (c[15:8] !== 8'b10110000) begin failures++; $display("FAIL load_cat1: got %b want 10110000", c[15:8]); end
        checks++; if (c[31:24] !== 8'b11111001) begin failures++; $display("FAIL load_cat3: got %b want 11111001", c[31:24]); end
        checks++; if (sl !== 8'b11100100) begin failures++; $display("FAIL load_slot_seq: got %b want 11100100", sl); end
        e = exp_out(2, q[15:0], q[19:16], 4'hF);
        checks++;
        if ({a[11:8], c[23:16]} !== e) begin
            failures++;
            $display("FAIL load_slot2: got an=%b cat=%b want an=%b cat=%b", a[11:8], c[23:16], e[11:8], e[7:0]);
        end
    endtask

    task automatic test_patterns;
        logic [19:0] pats[4] = '{{4'b1010, 16'h89AB}, {4'b0100, 16'hCDEF},
                                 {4'b1000, 16'h5670}, {4'b0000, 16'h0F06}};
        logic [15:0] a; logic [31:0] c; logic [7:0] sl; logic [11:0] e; logic [19:0] q; bit ok;
        for (int k = 0; k < 4; k++) begin
            wait_frame(ok);
            send(pats[k][15:0], pats[k][19:16], ok);
            capture_frame(-1, a, c, sl, ok);
            checks++; if (!ok) begin failures++; $display("FAIL patterns_frame%0d: frame_done timeout", k); end
            q = (exp_q.size() > 0) ? exp_q.pop_front() : 20'h0;
            for (int s = 0; s < 4; s++) begin
                e = exp_out(s, q[15:0], q[19:16], 4'hF);
                checks++;
                if ({a[4*s +: 4], c[8*s +: 8]} !== e) begin
                    failures++;
                    $display("FAIL patterns%0d slot%0d: got an=%b cat=%b want an=%b cat=%b",
                             k, s, a[4*s +: 4], c[8*s +: 8], e[11:8], e[7:0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] a; logic [31:0] c; logic [7:0] sl; logic [11:0] e; logic [19:0] q;
        bit ok; bit seen; int early;
        wait_frame(ok);
        send(16'hA5C3, 4'b0010, ok);
        load_data = 16'h7E19; load_dp = 4'b0100; load_valid = 1'b1;
        checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_busy: got %b want 0", load_ready); end
        seen = 1'b0; early = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
            if (load_ready) early++;
        end
        checks++; if (!seen) begin failures++; $display("FAIL b2b_wrap: frame_done timeout"); end
        checks++; if (early != 0) begin failures++; $display("FAIL b2b_early_ready: got %0d cycles want 0", early); end
        checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_wrap: got %b want 1", load_ready); end
        @(posedge clk_in);
        exp_q.push_back({4'b0100, 16'h7E19});
        @(negedge clk_in);
        load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL b2b_b_pending: got %b want 0", load_ready); end
        for (int f = 0; f < 2; f++) begin
            capture_frame((f == 0) ? 1 : -1, a, c, sl, ok);
            checks++; if (!ok) begin failures++; $display("FAIL b2b_frame%0d: frame_done timeout", f); end
            q = (exp_q.size() > 0) ? exp_q.pop_front() : 20'h0;
            for (int s = 0; s < 4; s++) begin
                e = exp_out(s, q[15:0], q[19:16], 4'hF);
                checks++;
                if ({a[4*s +: 4], c[8*s +: 8]} !== e) begin
                    failures++;
                    $display("FAIL b2b_frame%0d slot%0d: got an=%b cat=%b want an=%b cat=%b",
                             f, s, a[4*s +: 4], c[8*s +: 8], e[11:8], e[7:0]);
                end
            end
            if (f == 0) begin
                checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL b2b_still_pending: got %b want 0", load_ready); end
            end
        end
    endtask

    task automatic test_brightness;
        int lit; int fd; int want; bit ok;
        digit_en = 4'hF;
        for (int b = 0; b < 4; b++) begin
            bright = BRIGHT_W'(b);
            wait_frame(ok);
            wait_frame(ok);
            checks++; if (!ok) begin failures++; $display("FAIL bright%0d_frame: frame_done timeout", b); end
            lit = 0; fd = 0;
            for (int i = 1; i <= 4 * TICK_DIV; i++) begin
                @(negedge clk_in);
                if (an !== 4'hF) lit++;
                if (frame_done) fd++;
            end
            want = 0;
            for (int t = GUARD_CYC; t < TICK_DIV; t++) if ((t % (1 << BRIGHT_W)) <= b) want++;
            want = want * 4;
            checks++; if (lit != want) begin failures++; $display("FAIL bright%0d_duty: got %0d lit cycles want %0d", b, lit, want); end
            checks++; if (fd != 1) begin failures++; $display("FAIL bright%0d_frame_done: got %0d pulses want 1", b, fd); end
        end
        bright = 2'd3;
    endtask

    task automatic test_digit_en;
        int bad; int shown[4]; int sl; bit ok;
        digit_en = 4'b0101; bright = 2'd3;
        wait_frame(ok);
        wait_frame(ok);
        checks++; if (!ok) begin failures++; $display("FAIL en_frame: frame_done timeout"); end
        bad = 0; shown = '{0, 0, 0, 0};
        for (int i = 1; i <= 4 * TICK_DIV; i++) begin
            @(negedge clk_in);
            sl = (i - 1) / TICK_DIV;
            if (sl == 1 || sl == 3) begin
                if (an !== 4'hF || cat !== 8'hFF) bad++;
            end else if (an !== 4'hF) begin
                shown[sl]++;
            end
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL en_disabled_lit: got %0d cycles want 0", bad); end
        checks++; if (shown[0] != 6) begin failures++; $display("FAIL en_slot0: got %0d lit want 6", shown[0]); end
        checks++; if (shown[2] != 6) begin failures++; $display("FAIL en_slot2: got %0d lit want 6", shown[2]); end
        digit_en = 4'hF;
    endtask

    task automatic test_async_reset;
        logic [15:0] a; logic [31:0] c; logic [7:0] sl; logic [11:0] e; logic [19:0] q; bit ok;
        digit_en = 4'hF; bright = 2'd3;
        wait_frame(ok);
        send(16'h4321, 4'b0000, ok);
        wait_frame(ok);
        checks++; if (!ok) begin failures++; $display("FAIL arst_frame: frame_done timeout"); end
        q = (exp_q.size() > 0) ? exp_q.pop_front() : 20'h0;
        repeat (2 * TICK_DIV + SAMPLE_TICK) @(negedge clk_in);
        checks++; if (an !== 4'b1011) begin failures++; $display("FAIL arst_pre_an: got %b want 1011", an); end
        checks++; if (cat !== 8'b10110000) begin failures++; $display("FAIL arst_pre_cat: got %b want 10110000", cat); end
        load_data = 16'h9999; load_dp = 4'hF; load_valid = 1'b1;
        @(posedge clk_in);
        #1;
        checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL arst_pending: got %b want 0", load_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL arst_an: got %h want F", an); end
        checks++; if (cat !== 8'hFF) begin failures++; $display("FAIL arst_cat: got %h want FF", cat); end
        checks++; if (slot_sel !== 2'd0) begin failures++; $display("FAIL arst_slot: got %0d want 0", slot_sel); end
        checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL arst_ready: got %b want 1", load_ready); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL arst_frame_done: got %b want 0", frame_done); end
        load_valid = 1'b0;
        exp_q.delete();
        @(negedge clk_in);
        rst_n = 1'b1;
        capture_frame(-1, a, c, sl, ok);
        checks++; if (!ok) begin failures++; $display("FAIL arst_post_frame: frame_done timeout"); end
        for (int s = 0; s < 4; s++) begin
            e = exp_out(s, 16'h0, 4'h0, 4'hF);
            checks++;
            if ({a[4*s +: 4], c[8*s +: 8]} !== e) begin
                failures++;
                $display("FAIL arst_discard slot%0d: got an=%b cat=%b want an=%b cat=%b",
                         s, a[4*s +: 4], c[8*s +: 8], e[11:8], e[7:0]);
            end
        end
    endtask

    task automatic test_leading_zero;
        logic [15:0] a; logic [31:0] c; logic [7:0] sl; logic [19:0] q; bit ok;
        logic [11:0] want[4];
        logic [3:0]  dps[2] = '{4'b0000, 4'b0100};
        for (int k = 0; k < 2; k++) begin
            wait_frame(ok);
            send(16'h0050, dps[k], ok);
            capture_frame(-1, a, c, sl, ok);
            checks++; if (!ok) begin failures++; $display("FAIL lz_frame%0d: frame_done timeout", k); end
            q = (exp_q.size() > 0) ? exp_q.pop_front() : 20'h0;
            want[0] = {4'b1110, 8'b11000000};
            want[1] = {4'b1101, 8'b10010010};
`ifdef LEADING_ZERO_BLANK_EN
            want[2] = (k == 0) ? {4'hF, 8'hFF} : {4'b1011, 8'b01000000};
            want[3] = {4'hF, 8'hFF};
`else
            want[2] = (k == 0) ? {4'b1011, 8'b11000000} : {4'b1011, 8'b01000000};
            want[3] = {4'b0111, 8'b11000000};
`endif
            for (int s = 0; s < 4; s++) begin
                checks++;
                if ({a[4*s +: 4], c[8*s +: 8]} !== want[s]) begin
                    failures++;
                    $display("FAIL lz%0d slot%0d: got an=%b cat=%b want an=%b cat=%b (queued %h)",
                             k, s, a[4*s +: 4], c[8*s +: 8], want[s][11:8], want[s][7:0], q);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_display();
        test_patterns();
        test_back_to_back();
        test_brightness();
        test_digit_en();
        test_async_reset();
        test_leading_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
